// File: rtl/pattern_entry_if.sv
// Bundles the guess-entry signals between the game controller/board side and
// pattern_entry.
//   master : drives sw, btn_submit, round_start, round_abort; observes results
//   slave  : pattern_entry side; drives entry_pattern, check_en, entry_done,
//            entry_open, timed_out
interface pattern_entry_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] sw;
    logic             btn_submit;
    logic             round_start;
    logic             round_abort;
    logic [WIDTH-1:0] entry_pattern;
    logic             check_en;
    logic             entry_done;
    logic             entry_open;
    logic             timed_out;

    modport master (
        output sw, btn_submit, round_start, round_abort,
        input  entry_pattern, check_en, entry_done, entry_open, timed_out
    );

    modport slave (
        input  sw, btn_submit, round_start, round_abort,
        output entry_pattern, check_en, entry_done, entry_open, timed_out
    );
endinterface

// File: rtl/pattern_entry.sv
// Guess-entry front end: synchronises the 16 slide switches and the submit
// button, debounces the button, accepts one guess per round and presents it
// to the pattern comparator as entry_pattern with a check_en window of
// CHECK_HOLD cycles, followed by a one-cycle entry_done pulse.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : pattern_entry_if.slave
//              in : sw, btn_submit (raw, async), round_start, round_abort
//              out: entry_pattern, check_en, entry_done, entry_open, timed_out
// Optional macro ENTRY_TIMEOUT_EN: forces a submission after TIMEOUT_CYCLES
// cycles in ENTRY and reports it on timed_out; otherwise timed_out is 0.
module pattern_entry #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CHECK_HOLD      = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
    input  logic            clk,
    input  logic            rst,
    pattern_entry_if.slave  bus
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (CHECK_HOLD > 1) ? $clog2(CHECK_HOLD) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CHECK_HOLD - 1);

    if (CHECK_HOLD < 1) begin : g_bad_hold
        $error("CHECK_HOLD must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ENTRY, PRESENT, RELEASE} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sw_m_q, sw_s_q;
    logic              btn_m_q, btn_s_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              btn_db_q, btn_db_prev_q;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              submit_evt;
`ifdef ENTRY_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]       tmo_q, tmo_d;
    logic              timed_out_q, timed_out_d;
`endif

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m_q  <= '0;
            sw_s_q  <= '0;
            btn_m_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sw_m_q  <= bus.sw;
            sw_s_q  <= sw_m_q;
            btn_m_q <= bus.btn_submit;
            btn_s_q <= btn_m_q;
        end
    end

    // Debouncer: accept a new level only after it has differed from the
    // current one for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
        end else begin
            btn_db_prev_q <= btn_db_q;
            if (btn_s_q == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                btn_db_q <= btn_s_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    // A press already held when ENTRY opens never shows a rising edge here
    assign submit_evt = btn_db_q & ~btn_db_prev_q;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hold_d    = hold_q;
`ifdef ENTRY_TIMEOUT_EN
        tmo_d       = tmo_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ENTRY_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (bus.round_start) state_d = ENTRY;
            end
            ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
                tmo_d = tmo_q + 32'd1;
`endif
                if (submit_evt) begin
                    pattern_d = sw_s_q;
                    hold_d    = '0;
                    state_d   = PRESENT;
`ifdef ENTRY_TIMEOUT_EN
                    timed_out_d = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    pattern_d   = sw_s_q;
                    hold_d      = '0;
                    timed_out_d = 1'b1;
                    state_d     = PRESENT;
`endif
                end
            end
            PRESENT: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides any transition or capture decided above
        if (bus.round_abort) begin
            state_d   = IDLE;
            pattern_d = pattern_q;
`ifdef ENTRY_TIMEOUT_EN
            timed_out_d = timed_out_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            hold_q    <= '0;
`ifdef ENTRY_TIMEOUT_EN
            tmo_q       <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hold_q    <= hold_d;
`ifdef ENTRY_TIMEOUT_EN
            tmo_q       <= tmo_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign bus.entry_pattern = pattern_q;
    assign bus.check_en      = (state_q == PRESENT);
    assign bus.entry_done    = (state_q == RELEASE);
    assign bus.entry_open    = (state_q == ENTRY);
`ifdef ENTRY_TIMEOUT_EN
    assign bus.timed_out     = timed_out_q;
`else
    assign bus.timed_out     = 1'b0;
`endif

endmodule
